// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } ld_state_e;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int unsigned SYNC_BYTES     = 1;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CSUM_BYTES     = 1;

  // Running XOR checksum over data bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian data bytes into 32-bit words; word_valid_o flags the 4th byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_WORD - 1);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  lane_q, lane_d;

  // Newest byte enters at the top so earlier bytes settle into the low lanes.
  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    if (clr_i) begin
      shift_d = 24'd0;
      lane_d  = 2'd0;
    end else if (byte_en_i) begin
      shift_d = {byte_i, shift_q[23:8]};
      lane_d  = lane_q + 2'd1;
    end else begin
      shift_d = shift_q;
      lane_d  = lane_q;
    end
  end

  // Shift register and lane counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 24'd0;
      lane_q  <= 2'd0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

  assign word_valid_o = byte_en_i && !clr_i && (lane_q == LANE_LAST);
  assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Serial frame loader: receives a length-prefixed, XOR-checked image and writes it
// word by word into instruction memory port B while holding the core in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        en_B,
  output logic        write_en_B,
  output logic [31:0] addr_B,
  output logic [31:0] data_in_B,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MAX_W   = 17'(MAX_WORDS);

  ld_state_e       state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            en_q, en_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            asm_clr_s;
  logic            asm_en_s;
  logic            word_valid_s;
  logic [31:0]     word_s;
  logic [15:0]     len_full_s;
  logic [16:0]     idx_inc_s;

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst_n        (reset),
    .clr_i        (asm_clr_s),
    .byte_en_i    (asm_en_s),
    .byte_i       (rx_data),
    .word_valid_o (word_valid_s),
    .word_o       (word_s)
  );

  assign len_full_s = {rx_data, len_q[7:0]};
  assign idx_inc_s  = {1'b0, idx_q} + 17'd1;

  // Frame FSM: next state, counters, checksum and the registered memory-port outputs.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    to_cnt_d  = to_cnt_q;
    en_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    asm_clr_s = 1'b0;
    asm_en_s  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        to_cnt_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d   = ST_LEN0;
          hold_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          csum_d    = 8'd0;
          asm_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: begin
        if (!rx_valid) begin
          // Idle cycle inside a frame: abort once the allowed gap is used up.
          if (to_cnt_q == TO_LAST) begin
            state_d  = ST_ERROR;
            err_d    = 1'b1;
            hold_d   = 1'b1;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else begin
          to_cnt_d = '0;
          case (state_q)
            ST_LEN0: begin
              len_d   = {8'd0, rx_data};
              state_d = ST_LEN1;
            end
            ST_LEN1: begin
              len_d = len_full_s;
              if (len_full_s == 16'd0) begin
                state_d = ST_CSUM;
              end else if ({1'b0, len_full_s} > MAX_W) begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
                hold_d  = 1'b1;
              end else begin
                state_d   = ST_DATA;
                idx_d     = 16'd0;
                asm_clr_s = 1'b1;
              end
            end
            ST_DATA: begin
              asm_en_s = 1'b1;
              csum_d   = csum_next(csum_q, rx_data);
              if (word_valid_s) begin
                en_d   = 1'b1;
                addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
                data_d = word_s;
                idx_d  = idx_inc_s[15:0];
                if (idx_inc_s == {1'b0, len_q}) begin
                  state_d = ST_CSUM;
                end else begin
                  state_d = ST_DATA;
                end
              end else begin
                state_d = ST_DATA;
              end
            end
            ST_CSUM: begin
              if (rx_data == csum_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
              end else begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
                hold_d  = 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      len_q    <= 16'd0;
      idx_q    <= 16'd0;
      csum_q   <= 8'd0;
      to_cnt_q <= '0;
      en_q     <= 1'b0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      to_cnt_q <= to_cnt_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rx_ready   = 1'b1;
  assign en_B       = en_q;
  assign write_en_B = en_q;
  assign addr_B     = addr_q;
  assign data_in_B  = data_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: valid, bad-checksum, oversize, junk, timeout and reset cases.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        en_B;
  logic        write_en_B;
  logic [31:0] addr_B;
  logic [31:0] data_in_B;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int we_mis   = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int base;

  imem_loader #(
    .BASE_ADDR      (32'h0000_0000),
    .MAX_WORDS      (1024),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .en_B       (en_B),
    .write_en_B (write_en_B),
    .addr_B     (addr_B),
    .data_in_B  (data_in_B),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: logs every cycle with en_B high, sampled mid-cycle.
  always @(negedge clk) begin
    if (en_B === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = addr_B;
        wr_data[wr_cnt] = data_in_B;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (en_B !== write_en_B) we_mis = we_mis + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] csum);
    logic [7:0] body [11];
    body = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 11; i++) send_byte(body[i]);
    send_byte(csum);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reset    = 1'b0;
    idle(3);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_en", {30'd0, en_B, write_en_B}, 32'd0);
    check("rst_flags", {29'd0, core_hold, load_done, load_error}, 32'd0);
    check("rst_addr", addr_B, 32'd0);
    check("rst_data", data_in_B, 32'd0);
    reset = 1'b1;
    idle(2);

    // Valid two-word frame.
    base = wr_cnt;
    send_byte(8'hA5);
    check("sync_hold", {31'd0, core_hold}, 32'd1);
    rx_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: send_byte(8'h02);
        1: send_byte(8'h00);
        2: send_byte(8'h13);
        6: send_byte(8'h93);
        8: send_byte(8'h10);
        default: send_byte(8'h00);
      endcase
    end
    send_byte(8'h90);
    check("ok_done", {31'd0, load_done}, 32'd1);
    check("ok_hold", {31'd0, core_hold}, 32'd0);
    check("ok_err", {31'd0, load_error}, 32'd0);
    idle(2);
    check("ok_wr_cnt", wr_cnt - base, 32'd2);
    check("ok_addr0", wr_addr[base], 32'h0000_0000);
    check("ok_data0", wr_data[base], 32'h0000_0013);
    check("ok_addr1", wr_addr[base+1], 32'h0000_0004);
    check("ok_data1", wr_data[base+1], 32'h0010_0093);

    // Junk bytes ahead of a frame are ignored.
    base = wr_cnt;
    send_byte(8'h00);
    check("junk0_hold", {31'd0, core_hold}, 32'd0);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("junk_hold", {31'd0, core_hold}, 32'd0);
    check("junk_done_kept", {31'd0, load_done}, 32'd1);
    send_frame(8'h90);
    idle(2);
    check("junk_frame_done", {30'd0, load_done, core_hold}, 32'd2);
    check("junk_wr_cnt", wr_cnt - base, 32'd2);
    check("junk_data1", wr_data[base+1], 32'h0010_0093);

    // Bad checksum: writes stay, frame flagged.
    base = wr_cnt;
    send_frame(8'h91);
    check("bad_err", {31'd0, load_error}, 32'd1);
    check("bad_hold", {31'd0, core_hold}, 32'd1);
    check("bad_done", {31'd0, load_done}, 32'd0);
    idle(2);
    check("bad_wr_cnt", wr_cnt - base, 32'd2);
    check("bad_addr0", wr_addr[base], 32'h0000_0000);
    check("bad_data1", wr_data[base+1], 32'h0010_0093);

    // Oversize count N=1025.
    base = wr_cnt;
    send_byte(8'hA5);
    check("sync_clears_err", {31'd0, load_error}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h04);
    check("over_err", {31'd0, load_error}, 32'd1);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(2);
    check("over_wr_cnt", wr_cnt - base, 32'd0);

    // Timeout after 16 idle cycles mid-DATA.
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    idle(15);
    check("to_err_early", {31'd0, load_error}, 32'd0);
    idle(1);
    check("to_err", {31'd0, load_error}, 32'd1);
    check("to_hold", {31'd0, core_hold}, 32'd1);
    idle(3);
    check("to_wr_cnt", wr_cnt - base, 32'd0);

    // Reset one cycle after the 4th data byte of word 0.
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(1);
    reset = 1'b0;
    #1;
    check("mid_rst_flags", {29'd0, core_hold, load_done, load_error}, 32'd0);
    check("mid_rst_en", {30'd0, en_B, write_en_B}, 32'd0);
    check("mid_rst_addr", addr_B, 32'd0);
    check("mid_rst_data", data_in_B, 32'd0);
    check("mid_rst_wr_before", wr_cnt - base, 32'd1);
    idle(2);
    reset = 1'b1;
    base = wr_cnt;
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    idle(4);
    check("post_rst_wr_cnt", wr_cnt - base, 32'd0);
    check("post_rst_flags", {29'd0, core_hold, load_done, load_error}, 32'd0);

    check("we_matches_en", we_mis, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000; byte address of the first loaded word, word-aligned.
REQ-002 Parameter MAX_WORDS, default 1024; largest accepted word count.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000; allowed idle cycles between bytes while a frame is in progress.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  byte from the serial receiver.
REQ-007 rx_valid  input  1  rx_data holds a valid byte this cycle.
REQ-008 rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-009 en_B  output  1  instruction-memory port B enable.
REQ-010 write_en_B  output  1  instruction-memory port B write strobe.
REQ-011 addr_B  output  32  instruction-memory port B byte address.
REQ-012 data_in_B  output  32  instruction-memory port B write data.
REQ-013 core_hold  output  1  active-high; holds the core in reset while loading.
REQ-014 load_done  output  1  last frame loaded and verified.
REQ-015 load_error  output  1  last frame aborted.

Function
REQ-016 Frame format, in byte order:
- SYNC 0xA5
- LEN_LO, LEN_HI: 16-bit word count N
- 4*N data bytes, little-endian per word (the first byte is bits 7:0)
- CSUM: XOR of all data bytes (0x00 when N=0).
REQ-017 States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
REQ-018 rx_ready SHALL be 1 in every state; the loader accepts one byte per cycle, back-to-back.
REQ-019 IDLE/DONE/ERROR: a byte of 0xA5 moves the FSM to LEN0, sets core_hold=1, and clears load_done and load_error; any other byte is discarded.
REQ-020 LEN1 acceptance:
- N=0 -> CSUM
- N>MAX_WORDS -> ERROR, with no writes
- otherwise -> DATA, with the word index cleared.
REQ-021 DATA: on acceptance of the 4th byte of a word, en_B and write_en_B SHALL pulse high for exactly the next cycle.
- addr_B = BASE_ADDR + 4*index; data_in_B = the assembled word.
- The index then increments.
REQ-022 A byte accepted in the same cycle as a write pulse SHALL be assembled into the next word without loss.
REQ-023 After word N is written, the FSM moves to CSUM. A matching CSUM byte -> DONE; a mismatch -> ERROR.
REQ-024 DONE: load_done=1, core_hold=0. ERROR: load_error=1, core_hold=1. Both states persist until the next 0xA5 byte.
REQ-025 In LEN0 through CSUM, a timeout counter counts cycles without an accepted byte.
- Reaching TIMEOUT_CYCLES -> ERROR.
- Every accepted byte clears the counter.
REQ-026 Writes completed before an error SHALL NOT be rolled back.
REQ-027 en_B and write_en_B SHALL be 0 in every cycle not described in REQ-021; addr_B and data_in_B are don't-care when en_B=0.

Reset
REQ-028 While reset=0:
- FSM=IDLE
- en_B, write_en_B, core_hold, load_done, load_error = 0
- addr_B and data_in_B = 0
- counters and checksum cleared
- rx_ready = 1
REQ-029 A reset asserted mid-frame SHALL abort the frame, with no pending write pulse issued after reset release.

Structure
REQ-030 A shared package SHALL hold the following:
- the state enum
- SYNC_BYTE = 8'hA5
- the frame byte-count constants.
REQ-031 One sub-module, word_assembler, SHALL be used. It holds the byte shift register and the byte-lane counter, and outputs word_valid.

Verification
REQ-032 Valid frame: A5 02 00 13 00 00 00 93 00 10 00 90.
- Writes addr 0x0 = 0x00000013 and addr 0x4 = 0x00100093, each a 1-cycle pulse.
- Then load_done=1 and core_hold=0.
REQ-033 Bad checksum: the same frame with CSUM 0x91 -> both writes occur, then load_error=1, core_hold=1, load_done=0.
REQ-034 Oversize: A5 01 04 (N=1025) -> ERROR immediately after LEN_HI, with zero write pulses.
REQ-035 Junk then frame: 00 FF 5A before the REQ-032 frame -> the junk is ignored, the result is identical to REQ-032, and core_hold stays 0 until the 0xA5 byte.
REQ-036 Timeout: with TIMEOUT_CYCLES=16, send A5 01 00 13, then no bytes for 16 cycles -> load_error=1, with no write.
REQ-037 Reset mid-DATA: pull reset low one cycle after the 4th data byte is accepted -> all outputs at their reset values, and no write pulse after release.
